// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: imem request/response, redirect from execute, and the
// decode-facing FIFO head. master = fetch_queue, slave = memory/decode side.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [31:0]   imem_req_addr;
    logic          imem_resp_valid;
    logic [31:0]   imem_resp_data;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          d_valid;
    logic          d_ready;
    logic [31:0]   d_pc;
    logic [31:0]   d_insn;
    logic [CW-1:0] fq_count;

    modport master (
        output imem_req_valid, imem_req_addr, d_valid, d_pc, d_insn, fq_count,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc, d_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, d_valid, d_pc, d_insn, fq_count,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc, d_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited imem
// requests and buffers {pc, insn} pairs for decode; redirect flushes and restarts.
module fetch_queue #(
    parameter logic [31:0] START_ADDR      = 32'h0100_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   f_pc;
    logic [OW-1:0] inflight, drop_cnt;
    logic [31:0]   ipc [MAX_OUTSTANDING];
    logic [QW-1:0] ipc_rd, ipc_wr;

    logic credit, req_valid, accept, resp, push, pop;

    function automatic logic [QW-1:0] ipc_next(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits count both FIFO entries and outstanding requests, so every
    // accepted response is guaranteed a slot (dropped ones are conservative).
    assign credit    = (int'(count) + int'(inflight) < DEPTH) && (int'(inflight) < MAX_OUTSTANDING);
    assign req_valid = rst && !bus.redirect && credit;
    assign accept    = req_valid && bus.imem_req_ready;
    assign resp      = bus.imem_resp_valid && (inflight != '0);
    assign push      = resp && !bus.redirect && (drop_cnt == '0);
    assign pop       = (count != '0) && bus.d_ready && !bus.redirect;

    assign head               = mem[rd_ptr];
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = f_pc;
    assign bus.d_valid        = (count != '0);
    assign bus.d_pc           = (count != '0) ? head.pc   : 32'h0;
    assign bus.d_insn         = (count != '0) ? head.insn : 32'h0;
    assign bus.fq_count       = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_pc     <= START_ADDR;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            ipc_rd   <= '0;
            ipc_wr   <= '0;
        end else begin
            // The in-flight PC FIFO tracks every outstanding request, dropped or not.
            if (accept) ipc_wr <= ipc_next(ipc_wr);
            if (resp)   ipc_rd <= ipc_next(ipc_rd);
            if (bus.redirect) begin
                f_pc     <= bus.redirect_pc & 32'hFFFF_FFFC;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                inflight <= inflight - OW'(resp);
                drop_cnt <= inflight - OW'(resp);
            end else begin
                if (accept) f_pc <= f_pc + 32'd4;
                inflight <= inflight + OW'(accept) - OW'(resp);
                if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) ipc[ipc_wr] <= f_pc;
        if (push)   mem[wr_ptr] <= '{pc: ipc[ipc_rd], insn: bus.imem_resp_data};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: behavioural imem with programmable latency, PC model and
// a scoreboard of expected {pc, insn} pushed on request acceptance.
module tb_fetch_queue;
    localparam logic [31:0] START = 32'h0100_0000;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.START_ADDR(START), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a3c_0f11;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] sb[$];
    int          cyc     = 0;
    int          lat     = 1;
    int          pops    = 0;
    int          max_out = 0;
    logic [31:0] exp_pc  = START;

    // imem response driver: head of pending list answers once its latency expires
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(pend[0].addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
    end

    // negedge monitor: inputs are stable, predicts what the coming edge does
    always @(negedge clk) begin : mon
        logic [63:0] e;
        if (!rst) begin
            pend.delete();
            sb.delete();
            exp_pc = START;
        end else begin
            if (bus.d_valid && bus.d_ready && !bus.redirect) begin
                pops++;
                if (sb.size() == 0) begin
                    chk("sb_underrun", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("d_pc", bus.d_pc, e[63:32]);
                    chk("d_insn", bus.d_insn, e[31:0]);
                end
            end
            if (bus.imem_resp_valid && pend.size() > 0) void'(pend.pop_front());
            if (bus.redirect) begin
                sb.delete();
                exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                chk("req_addr", bus.imem_req_addr, exp_pc);
                sb.push_back({exp_pc, mem_word(exp_pc)});
                pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
                exp_pc += 32'd4;
            end
            if (pend.size() > max_out) max_out = pend.size();
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_dvalid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.d_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int p0;
        int n;
        bus.imem_req_ready = 1'b1;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.d_ready        = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", bus.imem_req_valid, 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, START);
        chk("rst_d_valid", bus.d_valid, 32'd0);
        chk("rst_d_pc", bus.d_pc, 32'd0);
        chk("rst_d_insn", bus.d_insn, 32'd0);
        chk("rst_count", bus.fq_count, 32'd0);

        // release, first request, first decode output two cycles later
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("first_req_valid", bus.imem_req_valid, 32'd1);
        chk("first_req_addr", bus.imem_req_addr, START);
        @(negedge clk);
        chk("first_d_valid_early", bus.d_valid, 32'd0);
        @(negedge clk);
        chk("first_d_valid", bus.d_valid, 32'd1);
        chk("first_d_pc", bus.d_pc, START);

        // sustained one per cycle
        cycles(3);
        @(posedge clk); p0 = pops;
        repeat (10) @(posedge clk);
        chk("throughput", pops - p0, 32'd10);

        // decode stall: FIFO fills, requests stop
        #1 bus.d_ready = 1'b0;
        cycles(10);
        @(negedge clk);
        chk("stall_count", bus.fq_count, 32'd4);
        chk("stall_req_valid", bus.imem_req_valid, 32'd0);
        chk("max_outstanding", max_out <= MAXO, 32'd1);
        @(posedge clk); #1 bus.d_ready = 1'b1;
        p0 = pops;
        repeat (4) @(posedge clk);
        chk("drain_pops", pops - p0, 32'd4);

        // long latency, redirect with two requests in flight
        #1 lat = 3;
        n = 0;
        @(posedge clk);
        while (pend.size() != 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (n >= 50) chk("wait_two_outstanding", 32'd0, 32'd1);
        #1 bus.redirect = 1'b1; bus.redirect_pc = 32'h0100_0100;
        @(negedge clk);
        chk("redir_no_req", bus.imem_req_valid, 32'd0);
        @(posedge clk); #1 bus.redirect = 1'b0;
        @(negedge clk);
        chk("redir_d_valid", bus.d_valid, 32'd0);
        chk("redir_req_addr", bus.imem_req_addr, 32'h0100_0100);
        wait_dvalid("redir_timeout");
        chk("redir_head_pc", bus.d_pc, 32'h0100_0100);

        // redirect coinciding with a response and a pop, misaligned target
        #1 lat = 1;
        cycles(8);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0100_0103;
        @(negedge clk);
        chk("redir2_pre_resp", bus.imem_resp_valid, 32'd1);
        chk("redir2_pre_dvalid", bus.d_valid, 32'd1);
        @(posedge clk); #1 bus.redirect = 1'b0;
        @(negedge clk);
        chk("redir2_d_valid", bus.d_valid, 32'd0);
        chk("redir2_count", bus.fq_count, 32'd0);
        chk("redir2_req_addr", bus.imem_req_addr, 32'h0100_0100);
        chk("redir2_req_valid", bus.imem_req_valid, 32'd1);

        // PC wrap past 2^32
        cycles(4);
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
        cycles(1);
        bus.redirect = 1'b0;
        p0 = pops;
        wait_dvalid("wrap_timeout");
        chk("wrap_head_pc", bus.d_pc, 32'hFFFF_FFF8);
        cycles(6);
        chk("wrap_pops", pops - p0 >= 4, 32'd1);

        // random backpressure, latency and occasional redirects
        for (int i = 0; i < 300; i++) begin
            bus.imem_req_ready = 1'($urandom_range(0, 3) != 0);
            bus.d_ready        = 1'($urandom_range(0, 2) != 0);
            lat                = $urandom_range(1, 4);
            bus.redirect       = 1'($urandom_range(0, 24) == 0);
            bus.redirect_pc    = $urandom;
            cycles(1);
        end
        bus.redirect = 1'b0; bus.imem_req_ready = 1'b1; bus.d_ready = 1'b1; lat = 1;
        cycles(10);

        // async reset with entries queued
        bus.d_ready = 1'b0;
        cycles(5);
        #2;
        chk("pre_rst_count_nz", bus.fq_count != 0, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_d_valid", bus.d_valid, 32'd0);
        chk("async_count", bus.fq_count, 32'd0);
        chk("async_req_valid", bus.imem_req_valid, 32'd0);
        @(posedge clk); #1 rst = 1'b1; bus.d_ready = 1'b1;
        @(negedge clk);
        chk("rerun_req_addr", bus.imem_req_addr, START);
        chk("rerun_req_valid", bus.imem_req_valid, 32'd1);
        wait_dvalid("rerun_timeout");
        chk("rerun_head_pc", bus.d_pc, START);
        cycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
